// File: rtl/mem_byte_initiator_pkg.sv
// Shared definitions for the byte-serial load/store initiator: op encodings,
// FSM states and per-op helpers.
package mem_byte_initiator_pkg;

    localparam logic [2:0] MEM_LW  = 3'b000;
    localparam logic [2:0] MEM_SW  = 3'b001;
    localparam logic [2:0] MEM_LB  = 3'b010;
    localparam logic [2:0] MEM_LBU = 3'b011;
    localparam logic [2:0] MEM_SB  = 3'b100;
    localparam logic [2:0] MEM_LH  = 3'b101;
    localparam logic [2:0] MEM_LHU = 3'b110;
    localparam logic [2:0] MEM_SH  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic [2:0] op_bytes(input logic [2:0] op);
        case (op)
            MEM_LW, MEM_SW:          op_bytes = 3'd4;
            MEM_LH, MEM_LHU, MEM_SH: op_bytes = 3'd2;
            default:                 op_bytes = 3'd1;
        endcase
    endfunction

    function automatic logic op_is_store(input logic [2:0] op);
        op_is_store = (op == MEM_SW) || (op == MEM_SB) || (op == MEM_SH);
    endfunction

    // Words go out MSB first, halfwords/bytes LSB first.
    function automatic logic [7:0] store_byte(input logic [2:0] op,
                                              input logic [31:0] d,
                                              input logic [1:0] i);
        logic w;
        w = (op == MEM_SW);
        case (i)
            2'd0:    store_byte = w ? d[31:24] : d[7:0];
            2'd1:    store_byte = w ? d[23:16] : d[15:8];
            2'd2:    store_byte = w ? d[15:8]  : d[23:16];
            default: store_byte = w ? d[7:0]   : d[31:24];
        endcase
    endfunction

endpackage

// File: rtl/mem_byte_initiator_load_extend.sv
// Combinational load assembly: op plus four captured bytes (index 0..3)
// to a 32-bit sign/zero-extended result. Stores yield 0.
module load_extend
    import mem_byte_initiator_pkg::*;
(
    input  logic [2:0]      i_op,
    input  logic [3:0][7:0] i_bytes,
    output logic [31:0]     o_rdata
);

    always_comb begin
        o_rdata = '0;
        case (i_op)
            MEM_LW:  o_rdata = {i_bytes[0], i_bytes[1], i_bytes[2], i_bytes[3]};
            MEM_LH:  o_rdata = {{16{i_bytes[1][7]}}, i_bytes[1], i_bytes[0]};
            MEM_LHU: o_rdata = {16'h0000, i_bytes[1], i_bytes[0]};
            MEM_LB:  o_rdata = {{24{i_bytes[0][7]}}, i_bytes[0]};
            MEM_LBU: o_rdata = {24'h000000, i_bytes[0]};
            default: o_rdata = '0;
        endcase
    end

endmodule

// File: rtl/mem_byte_initiator.sv
// Multi-cycle load/store initiator sequencing core requests as byte transfers.
// Optional LSU_ALIGN_CHECK_EN rejects misaligned word/halfword accesses.
module mem_byte_initiator
    import mem_byte_initiator_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        mem_op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata
);

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [1:0]        r_idx;
    logic [2:0]        r_nbytes;
    logic [3:0][7:0]   r_bytes;
    logic              r_resp_valid, r_misaligned, r_mem_req, r_mem_we;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;

    logic              w_misal, w_last;
    logic [1:0]        w_idx_nxt;
    logic [3:0][7:0]   w_bytes;
    logic [31:0]       w_ld_data;

`ifdef LSU_ALIGN_CHECK_EN
    assign w_misal = ((op_bytes(mem_op) == 3'd4) && (addr[1:0] != 2'b00)) ||
                     ((op_bytes(mem_op) == 3'd2) && addr[0]);
`else
    assign w_misal = 1'b0;
`endif

    assign w_last    = mem_ack && ({1'b0, r_idx} == (r_nbytes - 3'd1));
    assign w_idx_nxt = r_idx + 2'd1;

    // Merge the byte arriving this cycle so the result is ready on the last ack.
    always_comb begin
        w_bytes        = r_bytes;
        w_bytes[r_idx] = mem_rdata;
    end

    load_extend u_load_extend (
        .i_op    (r_op),
        .i_bytes (w_bytes),
        .o_rdata (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_state_nxt = w_misal ? ST_RESP : ST_XFER;
            end
            ST_XFER: if (w_last) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_idx        <= '0;
            r_nbytes     <= '0;
            r_bytes      <= '0;
            r_resp_valid <= 1'b0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (req_valid) begin
                    r_op     <= mem_op;
                    r_addr   <= addr;
                    r_wdata  <= wdata;
                    r_idx    <= '0;
                    r_nbytes <= op_bytes(mem_op);
                    if (w_misal) begin
                        r_resp_valid <= 1'b1;
                        r_misaligned <= 1'b1;
                        r_rdata      <= '0;
                    end else begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= op_is_store(mem_op);
                        r_mem_addr  <= addr;
                        r_mem_wdata <= store_byte(mem_op, wdata, 2'd0);
                    end
                end
                ST_XFER: if (mem_ack) begin
                    r_bytes[r_idx] <= mem_rdata;
                    if (w_last) begin
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_ld_data;
                    end else begin
                        r_idx       <= w_idx_nxt;
                        r_mem_addr  <= r_addr + ADDR_W'(w_idx_nxt);
                        r_mem_wdata <= store_byte(r_op, r_wdata, w_idx_nxt);
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_misaligned <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign rdata      = r_rdata;
    assign misaligned = r_misaligned;
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_mem_byte_initiator.sv
// Bench for mem_byte_initiator: directed test-plan steps plus random requests
// against a byte-array memory and an arithmetic load/store reference.
module tb_mem_byte_initiator;
    import mem_byte_initiator_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [2:0]  mem_op;
    logic [31:0] addr, wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        misaligned, mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mem [256];
    logic [31:0] last_rdata;
    int          last_cyc;

    mem_byte_initiator #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .mem_op(mem_op), .addr(addr), .wdata(wdata), .resp_valid(resp_valid),
        .rdata(rdata), .misaligned(misaligned), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3);
        logic [31:0] v;
        case (op)
            MEM_LW:  v = b0 * 32'h1000000 + b1 * 32'h10000 + b2 * 32'h100 + b3;
            MEM_LH:  v = ((b1 * 32'h100 + b0) ^ 32'h8000) - 32'h8000;
            MEM_LHU: v = b1 * 32'h100 + b0;
            MEM_LB:  v = (b0 ^ 32'h80) - 32'h80;
            MEM_LBU: v = b0;
            default: v = 0;
        endcase
        return v;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle.
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input int wait_fix, input int rst_at);
        int n, w, cyc;
        bit st, mis;
        logic [7:0] b [4];
        logic [7:0] eb;
        logic [31:0] ai, exp;
        n   = (op == MEM_LW || op == MEM_SW) ? 4 :
              (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 1;
        st  = (op == MEM_SW || op == MEM_SB || op == MEM_SH);
        mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = (n == 4 && a[1:0] != 2'b00) || (n == 2 && a[0]);
`endif
        for (int k = 0; k < 4; k++) b[k] = 8'h00;
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; mem_op = op; addr = a; wdata = wd;
        @(negedge clk);
        cyc = 1;
        req_valid = 1'($urandom); mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
        if (mis) begin
            req_valid = 1'b0;
            chk("mis_resp_valid", 32'(resp_valid), 32'd1);
            chk("mis_flag", 32'(misaligned), 32'd1);
            chk("mis_rdata", rdata, 32'd0);
            chk("mis_no_req", 32'(mem_req), 32'd0);
            last_rdata = rdata; last_cyc = cyc;
            @(negedge clk);
            chk("mis_ready_back", 32'(req_ready), 32'd1);
            return;
        end
        for (int i = 0; i < n; i++) begin
            w  = (wait_fix >= 0) ? wait_fix : int'($urandom_range(0, 2));
            ai = a + 32'(i);
            eb = (op == MEM_SW) ? 8'(wd >> (8 * (3 - i))) : 8'(wd >> (8 * i));
            for (int j = 0; j <= w; j++) begin
                if (rst_at == i && j == 0) begin
                    rst_n = 1'b0; mem_ack = 1'b0; req_valid = 1'b0;
                    @(negedge clk);
                    chk("rst_mem_req", 32'(mem_req), 32'd0);
                    chk("rst_ready", 32'(req_ready), 32'd1);
                    chk("rst_no_resp", 32'(resp_valid), 32'd0);
                    rst_n = 1'b1;
                    repeat (3) begin
                        @(negedge clk);
                        chk("post_rst_no_resp", 32'(resp_valid), 32'd0);
                        chk("post_rst_no_req", 32'(mem_req), 32'd0);
                    end
                    return;
                end
                chk("xfer_req", 32'(mem_req), 32'd1);
                chk("xfer_addr", mem_addr, ai);
                chk("xfer_we", 32'(mem_we), 32'(st));
                if (st) chk("xfer_wdata", 32'(mem_wdata), 32'(eb));
                chk("xfer_no_resp", 32'(resp_valid), 32'd0);
                if (j == w) begin
                    mem_ack = 1'b1;
                    if (st) begin
                        mem[ai[7:0]] = eb;
                        mem_rdata = 8'($urandom);
                    end else begin
                        b[i] = mem[ai[7:0]];
                        mem_rdata = b[i];
                    end
                end else begin
                    mem_ack = 1'b0;
                    mem_rdata = 8'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
        end
        mem_ack = 1'b0; req_valid = 1'b0;
        exp = st ? 32'd0 : ref_load(op, b[0], b[1], b[2], b[3]);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_rdata", rdata, exp);
        chk("resp_misaligned", 32'(misaligned), 32'd0);
        chk("resp_no_req", 32'(mem_req), 32'd0);
        chk("resp_not_ready", 32'(req_ready), 32'd0);
        last_rdata = rdata; last_cyc = cyc;
        @(negedge clk);
        chk("resp_pulse_end", 32'(resp_valid), 32'd0);
        chk("ready_again", 32'(req_ready), 32'd1);
        chk("rdata_held", rdata, exp);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; mem_op = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        mem[8'h10] = 8'h12; mem[8'h11] = 8'h34; mem[8'h12] = 8'h56; mem[8'h13] = 8'h78;
        mem[8'h30] = 8'h80; mem[8'h40] = 8'h00; mem[8'h41] = 8'h80;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_mem_req0", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run(MEM_LW, 32'h10, 32'h0, 0, -1);
        chk("tp_lw_data", last_rdata, 32'h12345678);
        chk("tp_lw_cycle", 32'(last_cyc), 32'd5);

        run(MEM_SH, 32'h20, 32'hAABBCCDD, 2, -1);
        chk("tp_sh_b0", 32'(mem[8'h20]), 32'hDD);
        chk("tp_sh_b1", 32'(mem[8'h21]), 32'hCC);
        chk("tp_sh_cycle", 32'(last_cyc), 32'd7);

        run(MEM_LB, 32'h30, 32'h0, 1, -1);
        chk("tp_lb", last_rdata, 32'hFFFFFF80);
        run(MEM_LBU, 32'h30, 32'h0, 0, -1);
        chk("tp_lbu", last_rdata, 32'h00000080);
        run(MEM_LH, 32'h40, 32'h0, -1, -1);
        chk("tp_lh", last_rdata, 32'hFFFF8000);

`ifdef LSU_ALIGN_CHECK_EN
        run(MEM_LW, 32'h11, 32'h0, 0, -1);
        chk("tp_mis_cycle", 32'(last_cyc), 32'd1);
`else
        run(MEM_SW, 32'hFFFFFFFE, 32'h01020304, -1, -1);
        chk("tp_wrap_fe", 32'(mem[8'hFE]), 32'h01);
        chk("tp_wrap_ff", 32'(mem[8'hFF]), 32'h02);
        chk("tp_wrap_00", 32'(mem[8'h00]), 32'h03);
        chk("tp_wrap_01", 32'(mem[8'h01]), 32'h04);
`endif

        run(MEM_LW, 32'h10, 32'h0, 0, 2);
        run(MEM_LB, 32'h30, 32'h0, 0, -1);
        chk("tp_lb_after_rst", last_rdata, 32'hFFFFFF80);

        for (int t = 0; t < 60; t++)
            run(3'($urandom), $urandom, $urandom, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_byte_initiator.md
# mem_byte_initiator

Multi-cycle load/store initiator between the CPU memory stage and a byte-wide memory port. Accepts one request at a time from the core: `mem_op`, address and store data. Sequences the request as 1, 2 or 4 single-byte transfers with a req/ack handshake, then returns assembled, sign- or zero-extended load data. Byte ordering matches the data memory convention: words big-endian, halfwords little-endian.

## Interface
- `ADDR_W`, default 32: byte address width on both sides.
- `clk` input 1: the only clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `req_valid` input 1: core presents a request.
- `req_ready` output 1: high only in IDLE; a request is accepted on `req_valid && req_ready`.
- `mem_op` input 3: operation code. 000 lw, 001 sw, 010 lb, 011 lbu, 100 sb, 101 lh, 110 lhu, 111 sh.
- `addr` input ADDR_W: byte address of the access.
- `wdata` input 32: store data.
- `resp_valid` output 1: one-cycle pulse when the transaction completes (loads and stores).
- `rdata` output 32: load result; 0 for stores. Held until the next acceptance.
- `misaligned` output 1: qualifies `resp_valid`; only driven when `LSU_ALIGN_CHECK_EN` is defined, otherwise tied to 0.
- `mem_req` output 1: byte transfer request.
- `mem_we` output 1: transfer is a write; valid while `mem_req` is high.
- `mem_addr` output ADDR_W: byte address of the current transfer.
- `mem_wdata` output 8: write byte.
- `mem_ack` input 1: responder completes the transfer. May be asserted in the same cycle as `mem_req`.
- `mem_rdata` input 8: read byte; valid with `mem_ack` on reads.

## Operation
- FSM states: IDLE, XFER, RESP.
  - IDLE -> XFER on acceptance.
  - XFER -> RESP when the last byte is acked.
  - RESP -> IDLE unconditionally.
- On acceptance, latch `mem_op`, `addr` and `wdata`. Set byte count N: 4 for lw/sw, 2 for lh/lhu/sh, 1 for lb/lbu/sb. Clear byte index `i`.
- XFER:
  - Drive `mem_req`=1 and `mem_addr`=latched addr+`i` (modulo 2^ADDR_W; wraps at the top of the address space).
  - `mem_we`=1 for sw/sb/sh.
  - On a cycle with `mem_ack`: capture the read byte, increment `i`. `mem_req` stays high across back-to-back bytes.
- Write byte at index i:
  - sw: wdata[31:24], [23:16], [15:8], [7:0] for i=0..3.
  - sh: wdata[7:0], then [15:8].
  - sb: wdata[7:0].
- Load assembly, with b_i = byte read at index i:
  - lw: {b0,b1,b2,b3}.
  - lh: sign-extend {b1,b0}.
  - lhu: zero-extend {b1,b0}.
  - lb: sign-extend b0.
  - lbu: zero-extend b0.
- RESP: `resp_valid`=1 for exactly one cycle; `rdata` updated in the same cycle.
- `mem_ack` outside XFER is ignored. `req_valid` outside IDLE is ignored (no queuing).

## Timing
- Reset values: `req_ready`=1 (IDLE). `resp_valid`, `rdata`, `misaligned`, `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` all 0. Byte index 0.
- Reset mid-transaction abandons it: no `resp_valid`, `mem_req` low from the reset edge.
- Acceptance at cycle 0:
  - First `mem_req` at cycle 1.
  - With zero-wait ack, last byte at cycle N.
  - `resp_valid` at cycle N+1.
  - `req_ready` high again at cycle N+2.
- Each responder wait cycle adds one cycle. `mem_addr`, `mem_we` and `mem_wdata` are stable while `mem_req` is high and `mem_ack` is low.
- All outputs are registered except `req_ready`, which decodes the state register.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Misaligned accesses: lw/sw with addr[1:0]≠0; lh/lhu/sh with addr[0]≠0.
  - A misaligned access goes IDLE -> RESP with no memory traffic. `resp_valid`=1, `misaligned`=1, `rdata`=0 at cycle 1.
- `LSU_ALIGN_CHECK_EN` undefined: any address is accepted and sequenced bytewise; `misaligned` is constant 0.

## Structure
- Shared package: `mem_op` encodings (`MEM_LW`…`MEM_SH`), FSM state enum, and functions `op_bytes(op)`, `op_is_store(op)`.
- One sub-module: `load_extend`. Combinational; maps the op and 4 captured bytes to 32-bit `rdata`. Reusable by a future cached path.

## Test plan
- lw at 0x10, memory bytes 0x12,0x34,0x56,0x78, zero-wait -> `mem_addr` 0x10..0x13 in cycles 1-4; `rdata`=0x12345678 with `resp_valid` at cycle 5.
- sh wdata=0xAABBCCDD at 0x20, ack delayed 2 cycles per byte -> writes 0xDD@0x20 then 0xCC@0x21; `mem_wdata` stable while waiting; `resp_valid` at cycle 7.
- lb at 0x30 byte 0x80 -> `rdata`=0xFFFFFF80. lbu, same byte -> 0x00000080. lh bytes 0x00,0x80 -> 0xFFFF8000.
- sw at 0xFFFFFFFE (no align check) -> addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- `rst_n` low during 3rd byte of lw -> `mem_req`=0 and `req_ready`=1 after the edge, no `resp_valid`. A new lb completes normally afterwards.
- With `LSU_ALIGN_CHECK_EN`, lw at 0x11 -> no `mem_req`; `resp_valid`=1, `misaligned`=1, `rdata`=0 at cycle 1.
